nn_layer_scheduler: RTL and testbench

//  Sequences the MAC accelerator FSM across a multi-layer network without host intervention.

---
 rtl/nn_layer_scheduler_if.sv | 43 ++++
 rtl/nn_layer_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_nn_layer_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_scheduler_if.sv
// Bundle between the host config/status registers, the layer scheduler
// and the MAC accelerator FSM.
//
// Handshake semantics: there is no valid/ready pair on this bus. The
// single-cycle strobes (cfg_we, run, abort, neuron_done, acc_start, done)
// count once for every rising clock edge at which they are high.
// run is taken only while the scheduler is idle. Otherwise it is dropped.
// cfg_we is taken only while busy is low. neuron_done counts only in the
// RUN state.
interface nn_layer_scheduler_if;
  logic        cfg_we;
  logic [2:0]  cfg_layer;
  logic [1:0]  cfg_field;
  logic [15:0] cfg_wdata;
  logic [3:0]  num_layers;
  logic        run;
  logic        abort;
  logic        neuron_done;
  logic        acc_enable;
  logic        acc_start;
  logic [15:0] acc_base_addr;
  logic [15:0] acc_in_neurons;
  logic [15:0] acc_out_neurons;
  logic        bank_sel;
  logic [2:0]  layer_idx;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [3:0]  state_dbg;

  modport master (
    output cfg_we, cfg_layer, cfg_field, cfg_wdata, num_layers, run, abort, neuron_done,
    input  acc_enable, acc_start, acc_base_addr, acc_in_neurons, acc_out_neurons,
           bank_sel, layer_idx, busy, done, err, err_code, state_dbg
  );

  modport slave (
    input  cfg_we, cfg_layer, cfg_field, cfg_wdata, num_layers, run, abort, neuron_done,
    output acc_enable, acc_start, acc_base_addr, acc_in_neurons, acc_out_neurons,
           bank_sel, layer_idx, busy, done, err, err_code, state_dbg
  );
endinterface

// File: rtl/nn_layer_scheduler.sv
// Multi-layer sequencer for the MAC accelerator. It holds a per-layer
// descriptor table and validates each layer before it programs the
// accelerator. It counts completed output neurons and flips the ping-pong
// activation bank between layers.
module nn_layer_scheduler #(
  parameter int MAX_LAYERS = 8,
  parameter int PE_SIZE    = 16,
  parameter int DRAIN_CYC  = 8,
  parameter int TIMEOUT_W  = 20
) (
  input logic clk,
  input logic rst,
  nn_layer_scheduler_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_LOAD, S_START, S_RUN, S_DRAIN, S_NEXT, S_DONE, S_ERROR
  } state_t;

  localparam int DW = $clog2(DRAIN_CYC) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  // The descriptor table has no reset. The host must write it before run.
  logic [15:0] tbl_base_q [MAX_LAYERS];
  logic [15:0] tbl_in_q   [MAX_LAYERS];
  logic [15:0] tbl_out_q  [MAX_LAYERS];
  logic        tbl_we;

  state_t               state_q, state_d;
  logic [2:0]           layer_idx_q, layer_idx_d;
  logic [3:0]           num_layers_q, num_layers_d;
  logic                 bank_sel_q, bank_sel_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 acc_enable_q, acc_enable_d;
  logic [15:0]          base_q, base_d;
  logic [15:0]          in_q, in_d;
  logic [15:0]          out_q, out_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [15:0]          cur_in, cur_out;

  // Descriptor writes are allowed only while idle. Field 3 and out-of-range rows are dropped.
  always_comb begin
    tbl_we = bus.cfg_we && !busy_q && (int'(bus.cfg_layer) < MAX_LAYERS) &&
             (bus.cfg_field != 2'd3);
  end

  // Descriptor table storage.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      case (bus.cfg_field)
        2'd0:    tbl_base_q[bus.cfg_layer] <= bus.cfg_wdata;
        2'd1:    tbl_in_q[bus.cfg_layer]   <= bus.cfg_wdata;
        default: tbl_out_q[bus.cfg_layer]  <= bus.cfg_wdata;
      endcase
    end
  end

  // Next-state logic and datapath updates. abort overrides every state.
  always_comb begin
    state_d      = state_q;
    layer_idx_d  = layer_idx_q;
    num_layers_d = num_layers_q;
    bank_sel_d   = bank_sel_q;
    busy_d       = busy_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    acc_enable_d = acc_enable_q;
    base_d       = base_q;
    in_d         = in_q;
    out_d        = out_q;
    cnt_d        = cnt_q;
    wdog_d       = wdog_q;
    drain_d      = drain_q;
    cur_in       = tbl_in_q[layer_idx_q];
    cur_out      = tbl_out_q[layer_idx_q];

    if (bus.abort) begin
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      acc_enable_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.run) begin
            num_layers_d = bus.num_layers;
            layer_idx_d  = 3'd0;
            bank_sel_d   = 1'b0;
            err_d        = 1'b0;
            err_code_d   = 2'd0;
            if (bus.num_layers == 4'd0 || int'(bus.num_layers) > MAX_LAYERS) begin
              state_d    = S_ERROR;
              err_d      = 1'b1;
              err_code_d = 2'd1;
            end else begin
              busy_d  = 1'b1;
              state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // out_q still holds the previous layer's output count at this point.
          if (cur_in == 16'd0 || (cur_in % 16'(PE_SIZE)) != 16'd0 || cur_out == 16'd0) begin
            state_d      = S_ERROR;
            err_d        = 1'b1;
            err_code_d   = 2'd1;
            busy_d       = 1'b0;
            acc_enable_d = 1'b0;
          end else if (layer_idx_q != 3'd0 && cur_in != out_q) begin
            state_d      = S_ERROR;
            err_d        = 1'b1;
            err_code_d   = 2'd3;
            busy_d       = 1'b0;
            acc_enable_d = 1'b0;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          base_d       = tbl_base_q[layer_idx_q];
          in_d         = cur_in;
          out_d        = cur_out;
          acc_enable_d = 1'b1;
          cnt_d        = 16'd0;
          wdog_d       = '0;
          drain_d      = '0;
          state_d      = S_START;
        end
        S_START: state_d = S_RUN;
        S_RUN: begin
          if (bus.neuron_done) begin
            cnt_d  = cnt_q + 16'd1;
            wdog_d = '0;
            if (cnt_q + 16'd1 == out_q) state_d = S_DRAIN;
          end else if (wdog_q == WD_LAST) begin
            state_d      = S_ERROR;
            err_d        = 1'b1;
            err_code_d   = 2'd2;
            busy_d       = 1'b0;
            acc_enable_d = 1'b0;
          end else begin
            wdog_d = wdog_q + TIMEOUT_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) state_d = S_NEXT;
          else                       drain_d = drain_q + DW'(1);
        end
        S_NEXT: begin
          bank_sel_d = ~bank_sel_q;
          if ({1'b0, layer_idx_q} == num_layers_q - 4'd1) begin
            state_d      = S_DONE;
            busy_d       = 1'b0;
            acc_enable_d = 1'b0;
          end else begin
            layer_idx_d = layer_idx_q + 3'd1;
            state_d     = S_CHECK;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers. Reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      layer_idx_q  <= 3'd0;
      num_layers_q <= 4'd0;
      bank_sel_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      acc_enable_q <= 1'b0;
      base_q       <= 16'd0;
      in_q         <= 16'd0;
      out_q        <= 16'd0;
      cnt_q        <= 16'd0;
      wdog_q       <= '0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      layer_idx_q  <= layer_idx_d;
      num_layers_q <= num_layers_d;
      bank_sel_q   <= bank_sel_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      acc_enable_q <= acc_enable_d;
      base_q       <= base_d;
      in_q         <= in_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      wdog_q       <= wdog_d;
      drain_q      <= drain_d;
    end
  end

  // The start and done pulses are decoded from the state. The other outputs are direct flop outputs.
  always_comb begin
    bus.acc_start       = (state_q == S_START);
    bus.done            = (state_q == S_DONE);
    bus.acc_enable      = acc_enable_q;
    bus.acc_base_addr   = base_q;
    bus.acc_in_neurons  = in_q;
    bus.acc_out_neurons = out_q;
    bus.bank_sel        = bank_sel_q;
    bus.layer_idx       = layer_idx_q;
    bus.busy            = busy_q;
    bus.err             = err_q;
    bus.err_code        = err_code_q;
    bus.state_dbg       = state_q;
  end
endmodule

// File: tb/tb_nn_layer_scheduler.sv
// Directed bench for nn_layer_scheduler. The watchdog is shortened to 4 bits.
module tb_nn_layer_scheduler;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   start_cnt;
  int   done_cnt;
  int   s0;
  int   d0;
  logic got;

  nn_layer_scheduler_if bus ();

  nn_layer_scheduler #(.TIMEOUT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "global timeout");
  end

  // pulse counters, sampled on the falling edge
  initial begin
    start_cnt = 0;
    done_cnt  = 0;
  end
  always @(negedge clk) begin
    if (bus.acc_start === 1'b1) start_cnt <= start_cnt + 1;
    if (bus.done === 1'b1)      done_cnt  <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] layer, input logic [1:0] field, input logic [15:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_layer = layer;
    bus.cfg_field = field;
    bus.cfg_wdata = data;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_layer(input string tag, input logic [2:0] idx, input logic bank,
                          input logic [15:0] base, input int n_out);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (bus.acc_start === 1'b1) got = 1'b1;
    end
    chk({tag, "_start"}, got, 1);
    chk({tag, "_idx"}, bus.layer_idx, idx);
    chk({tag, "_bank"}, bus.bank_sel, bank);
    chk({tag, "_base"}, bus.acc_base_addr, base);
    step();
    for (int i = 0; i < n_out; i++) begin
      bus.neuron_done = 1'b1;
      step();
      bus.neuron_done = 1'b0;
      step();
    end
  endtask

  task automatic wait_done(input string tag);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (bus.done === 1'b1) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  task automatic wait_err(input string tag);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (bus.err === 1'b1) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_layer = 3'd0; bus.cfg_field = 2'd0; bus.cfg_wdata = 16'd0;
    bus.num_layers = 4'd0; bus.run = 1'b0; bus.abort = 1'b0; bus.neuron_done = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_enable", bus.acc_enable, 0);
    chk("rst_start", bus.acc_start, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_code", bus.err_code, 0);
    chk("rst_bank", bus.bank_sel, 0);
    chk("rst_base", bus.acc_base_addr, 0);

    // single layer, exact timing: in=32 out=4 base=0x100
    wr(3'd0, 2'd0, 16'h0100); wr(3'd0, 2'd1, 16'd32); wr(3'd0, 2'd2, 16'd4);
    bus.num_layers = 4'd1; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    chk("l1_busy_t1", bus.busy, 1);
    chk("l1_start_t1", bus.acc_start, 0);
    step();
    chk("l1_start_t2", bus.acc_start, 0);
    step();
    chk("l1_start_t3", bus.acc_start, 1);
    chk("l1_base", bus.acc_base_addr, 16'h0100);
    chk("l1_in", bus.acc_in_neurons, 16'd32);
    chk("l1_out", bus.acc_out_neurons, 16'd4);
    chk("l1_enable", bus.acc_enable, 1);
    chk("l1_bank_run", bus.bank_sel, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      bus.neuron_done = 1'b1;
      step();
      bus.neuron_done = 1'b0;
      if (i < 3) step();
    end
    // a stray pulse during DRAIN must be ignored
    bus.neuron_done = 1'b1;
    step();
    bus.neuron_done = 1'b0;
    repeat (7) step();
    chk("l1_done_early", bus.done, 0);
    chk("l1_busy_drain", bus.busy, 1);
    step();
    chk("l1_done", bus.done, 1);
    chk("l1_busy_done", bus.busy, 0);
    chk("l1_enable_done", bus.acc_enable, 0);
    chk("l1_bank_done", bus.bank_sel, 1);
    step();
    chk("l1_done_pulse", bus.done, 0);
    chk("l1_bank_hold", bus.bank_sel, 1);

    // three layers 64->16->16->10. A table write while busy is ignored.
    wr(3'd0, 2'd0, 16'h1000); wr(3'd0, 2'd1, 16'd64); wr(3'd0, 2'd2, 16'd16);
    wr(3'd1, 2'd0, 16'h2000); wr(3'd1, 2'd1, 16'd16); wr(3'd1, 2'd2, 16'd16);
    wr(3'd2, 2'd0, 16'h3000); wr(3'd2, 2'd1, 16'd16); wr(3'd2, 2'd2, 16'd10);
    s0 = start_cnt; d0 = done_cnt;
    bus.num_layers = 4'd3; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    chk("m3_busy", bus.busy, 1);
    bus.cfg_we = 1'b1; bus.cfg_layer = 3'd2; bus.cfg_field = 2'd0; bus.cfg_wdata = 16'hDEAD;
    step();
    bus.cfg_we = 1'b0;
    // with the run accepted two edges ago the FSM is in LOAD; acc_start is one edge away
    do_layer("m3_l0", 3'd0, 1'b0, 16'h1000, 16);
    do_layer("m3_l1", 3'd1, 1'b1, 16'h2000, 16);
    do_layer("m3_l2", 3'd2, 1'b0, 16'h3000, 10);
    wait_done("m3_done_seen");
    chk("m3_bank_end", bus.bank_sel, 1);
    step(); step();
    chk("m3_starts", start_cnt - s0, 3);
    chk("m3_dones", done_cnt - d0, 1);

    // bad descriptor: in=20
    wr(3'd0, 2'd1, 16'd20); wr(3'd0, 2'd2, 16'd4);
    s0 = start_cnt;
    bus.num_layers = 4'd1; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    step();
    chk("bad_err", bus.err, 1);
    chk("bad_code", bus.err_code, 1);
    chk("bad_busy", bus.busy, 0);
    step(); step();
    chk("bad_sticky", bus.err, 1);
    chk("bad_nostart", start_cnt - s0, 0);

    // num_layers out of range goes straight to ERROR
    bus.num_layers = 4'd0; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    chk("nl0_code", bus.err_code, 1);
    chk("nl0_busy", bus.busy, 0);
    step(); step();
    bus.num_layers = 4'd9; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    chk("nl9_err", bus.err, 1);
    chk("nl9_code", bus.err_code, 1);
    step(); step();

    // chain mismatch: layer0 out=16, layer1 in=32
    wr(3'd0, 2'd0, 16'h0200); wr(3'd0, 2'd1, 16'd32); wr(3'd0, 2'd2, 16'd16);
    wr(3'd1, 2'd0, 16'h0300); wr(3'd1, 2'd1, 16'd32); wr(3'd1, 2'd2, 16'd8);
    s0 = start_cnt;
    bus.num_layers = 4'd2; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    chk("ch_err_clear", bus.err, 0);
    chk("ch_code_clear", bus.err_code, 0);
    do_layer("ch_l0", 3'd0, 1'b0, 16'h0200, 16);
    wait_err("ch_err_seen");
    chk("ch_code", bus.err_code, 3);
    chk("ch_enable", bus.acc_enable, 0);
    chk("ch_busy", bus.busy, 0);
    chk("ch_bank", bus.bank_sel, 1);
    step(); step();
    chk("ch_starts", start_cnt - s0, 1);

    // watchdog: no neuron_done for 15 RUN cycles
    wr(3'd0, 2'd0, 16'h0400); wr(3'd0, 2'd1, 16'd16); wr(3'd0, 2'd2, 16'd4);
    bus.num_layers = 4'd1; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    step(); step();
    chk("wd_start", bus.acc_start, 1);
    repeat (15) step();
    chk("wd_err_early", bus.err, 0);
    chk("wd_busy_early", bus.busy, 1);
    step();
    chk("wd_err", bus.err, 1);
    chk("wd_code", bus.err_code, 2);
    chk("wd_busy", bus.busy, 0);
    chk("wd_enable", bus.acc_enable, 0);
    step(); step();

    // abort during RUN of layer 1 of 2, then rerun
    wr(3'd0, 2'd0, 16'h0500); wr(3'd0, 2'd1, 16'd16); wr(3'd0, 2'd2, 16'd16);
    wr(3'd1, 2'd0, 16'h0600); wr(3'd1, 2'd1, 16'd16); wr(3'd1, 2'd2, 16'd4);
    d0 = done_cnt;
    bus.num_layers = 4'd2; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    do_layer("ab_l0", 3'd0, 1'b0, 16'h0500, 16);
    do_layer("ab_l1", 3'd1, 1'b1, 16'h0600, 1);
    bus.abort = 1'b1;
    step(); bus.abort = 1'b0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_enable", bus.acc_enable, 0);
    chk("ab_start", bus.acc_start, 0);
    chk("ab_err", bus.err, 0);
    repeat (20) step();
    chk("ab_nodone", done_cnt - d0, 0);

    // run together with abort in IDLE: the run is dropped
    bus.run = 1'b1; bus.abort = 1'b1;
    step(); bus.run = 1'b0; bus.abort = 1'b0;
    chk("ra_busy", bus.busy, 0);
    step();
    chk("ra_busy2", bus.busy, 0);

    bus.num_layers = 4'd2; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    do_layer("re_l0", 3'd0, 1'b0, 16'h0500, 16);
    do_layer("re_l1", 3'd1, 1'b1, 16'h0600, 4);
    wait_done("re_done_seen");
    chk("re_bank", bus.bank_sel, 0);
    chk("re_err", bus.err, 0);
    step(); step();
    chk("re_dones", done_cnt - d0, 1);

    // rst mid-run: outputs clear, no done pulse
    d0 = done_cnt;
    bus.num_layers = 4'd1; bus.run = 1'b1;
    step(); bus.run = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("mr_busy", bus.busy, 0);
    chk("mr_enable", bus.acc_enable, 0);
    chk("mr_layer", bus.layer_idx, 0);
    chk("mr_base", bus.acc_base_addr, 0);
    repeat (20) step();
    chk("mr_nodone", done_cnt - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
